uart_tx_ctrl: RTL and testbench

//  Sequences one UART transmit frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_ctrl_timer.sv | 39 +++
 rtl/uart_tx_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared types and constants for the UART transmit controller.
//                Optional feature macro: UART_TX_PARITY_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Loadable down-counter marking the end of each bit period.
//                bit_end is high while the count is zero; the count holds at
//                zero rather than underflowing.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic bit_end
);

  localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign bit_end = (count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl
//  Description : UART transmit frame sequencer: start bit, 8 data bits LSB
//                first, optional parity bit, 1 or 2 stop bits. Registered tx,
//                set/reset ready flag and a one-cycle done pulse.
//                Optional feature macro: UART_TX_PARITY_EN (adds parity bit)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t  state, state_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       stop_cnt, stop_cnt_nxt;
  logic       tx_nxt, ready_nxt, done_nxt;
  logic       load;
  logic       bit_end;
  logic       accept;

  assign accept = (state == IDLE) && tx_start;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .bit_end (bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  // Parity is taken from the byte as latched, since the shift register is
  // consumed while the data bits go out.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx        <= LINE_IDLE;
      tx_ready  <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      stop_cnt  <= stop_cnt_nxt;
      tx        <= tx_nxt;
      tx_ready  <= ready_nxt;
      tx_done   <= done_nxt;
    end
  end

  // Next-state and next-output logic; the line value for each bit is set up
  // one edge early so tx comes straight from a flop.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    tx_nxt       = tx;
    ready_nxt    = tx_ready;
    done_nxt     = 1'b0;
    load         = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt = LINE_IDLE;
        if (tx_start) begin
          shift_nxt = tx_data;
          ready_nxt = 1'b0;
          tx_nxt    = LINE_START;
          load      = 1'b1;
          state_nxt = START;
        end
      end

      START: begin
        if (bit_end) begin
          load        = 1'b1;
          bit_cnt_nxt = '0;
          tx_nxt      = shift_reg[0];
          state_nxt   = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          load      = 1'b1;
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_nxt    = parity_bit;
            state_nxt = PARITY;
`else
            tx_nxt       = LINE_IDLE;
            stop_cnt_nxt = 1'b0;
            state_nxt    = STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            tx_nxt      = shift_reg[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          load         = 1'b1;
          tx_nxt       = LINE_IDLE;
          stop_cnt_nxt = 1'b0;
          state_nxt    = STOP;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          if (stop_cnt == LAST_STOP) begin
            // Timer is left at zero; the next accept reloads it.
            tx_nxt    = LINE_IDLE;
            ready_nxt = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            load         = 1'b1;
            stop_cnt_nxt = 1'b1;
          end
        end
      end

      default: begin
        tx_nxt    = LINE_IDLE;
        ready_nxt = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_ctrl
//  Description : Self-checking bench for uart_tx_ctrl. Three instances:
//                0 = 1 stop bit / even parity, 1 = 2 stop bits,
//                2 = 1 stop bit / odd parity. Frames are predicted from the
//                bit-level frame format; honours UART_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic [7:0] data;
  logic       tx0, tx1, tx2;
  logic       rdy0, rdy1, rdy2;
  logic       done0, done1, done2;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .tx_start(start[0]), .tx_data(data),
    .tx(tx0), .tx_ready(rdy0), .tx_done(done0));

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .tx_start(start[1]), .tx_data(data),
    .tx(tx1), .tx_ready(rdy1), .tx_done(done1));

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .tx_start(start[2]), .tx_data(data),
    .tx(tx2), .tx_ready(rdy2), .tx_done(done2));

  function automatic logic get_tx(int s);
    return (s == 0) ? tx0 : (s == 1) ? tx1 : tx2;
  endfunction
  function automatic logic get_rdy(int s);
    return (s == 0) ? rdy0 : (s == 1) ? rdy1 : rdy2;
  endfunction
  function automatic logic get_done(int s);
    return (s == 0) ? done0 : (s == 1) ? done1 : done2;
  endfunction

  // Reference: line level of bit slot k of a frame carrying byte d.
  function automatic logic exp_bit(int s, logic [7:0] d, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (P == 1 && k == 9) return (^d) ^ (s == 2);
    return 1'b1;
  endfunction

  function automatic int frame_len(int s);
    return CPB * (1 + 8 + P + ((s == 1) ? 2 : 1));
  endfunction

  // Starts a frame at the next edge and follows it cycle by cycle up to and
  // including the done cycle. A tx_start/0xFF glitch is injected after
  // sample glitch_at (negative = none). Entered and left on a falling edge.
  task automatic run_frame(input int s, input logic [7:0] d, input int glitch_at);
    int len;
    logic e;
    len = frame_len(s);
    start[s] = 1'b1;
    data     = d;
    @(posedge clk);
    @(negedge clk);
    start[s] = 1'b0;
    data     = 8'($urandom);
    for (int i = 0; i < len; i++) begin
      e = exp_bit(s, d, i / CPB);
      compared++;
      if (get_tx(s) !== e) begin
        failed++;
        $display("FAIL frame_tx dut%0d data=%h cyc=%0d got=%b exp=%b", s, d, i, get_tx(s), e);
      end
      compared++;
      if (get_rdy(s) !== 1'b0 || get_done(s) !== 1'b0) begin
        failed++;
        $display("FAIL frame_busy dut%0d cyc=%0d got rdy=%b done=%b exp rdy=0 done=0",
                 s, i, get_rdy(s), get_done(s));
      end
      if (i == glitch_at) begin
        start[s] = 1'b1;
        data     = 8'hFF;
      end else begin
        start[s] = 1'b0;
      end
      @(negedge clk);
    end
    start[s] = 1'b0;
    compared++;
    if (get_done(s) !== 1'b1 || get_rdy(s) !== 1'b1 || get_tx(s) !== 1'b1) begin
      failed++;
      $display("FAIL frame_end dut%0d got done=%b rdy=%b tx=%b exp 1 1 1",
               s, get_done(s), get_rdy(s), get_tx(s));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 3; s++) begin
        compared++;
        if (get_tx(s) !== 1'b1 || get_rdy(s) !== 1'b1 || get_done(s) !== 1'b0) begin
          failed++;
          $display("FAIL reset_idle dut%0d cyc=%0d got tx=%b rdy=%b done=%b exp 1 1 0",
                   s, i, get_tx(s), get_rdy(s), get_done(s));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_frames();
    run_frame(0, 8'hA5, -1);
    @(negedge clk);
    run_frame(2, 8'hA5, -1);
    @(negedge clk);
    run_frame(1, 8'hA5, -1);
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      for (int s = 0; s < 3; s++) begin
        run_frame(s, 8'($urandom), -1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_ignore_busy();
    run_frame(0, 8'hA5, 10);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      compared++;
      if (done0 !== 1'b0 || rdy0 !== 1'b1 || tx0 !== 1'b1) begin
        failed++;
        $display("FAIL ignore_idle cyc=%0d got done=%b rdy=%b tx=%b exp 0 1 1", i, done0, rdy0, tx0);
      end
      @(negedge clk);
    end
    run_frame(0, 8'($urandom), $urandom_range(0, frame_len(0) - 1));
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 8'hA5, -1);
    run_frame(0, 8'h3C, -1);
    run_frame(0, 8'($urandom), -1);
    @(negedge clk);
    run_frame(1, 8'hA5, -1);
    run_frame(1, 8'h3C, -1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d        = 8'hA5;
    start[0] = 1'b1;
    data     = d;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      compared++;
      if (tx0 !== exp_bit(0, d, i / CPB)) begin
        failed++;
        $display("FAIL abort_pre cyc=%0d got=%b exp=%b", i, tx0, exp_bit(0, d, i / CPB));
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3 * CPB * 11; i++) begin
      compared++;
      if (tx0 !== 1'b1 || rdy0 !== 1'b1 || done0 !== 1'b0) begin
        failed++;
        $display("FAIL abort_idle cyc=%0d got tx=%b rdy=%b done=%b exp 1 1 0", i, tx0, rdy0, done0);
      end
      @(negedge clk);
    end
    run_frame(0, 8'($urandom), -1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 3'b000;
    data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_frames();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
`default_nettype wire
